// File: rtl/core_pkg.sv
// Shared encodings for the memory stage: load sizes, store masks, FSM states,
// the response context latched at issue, and access-size helpers.
package core_pkg;

  localparam int unsigned XLEN_W = 32;

  // Load size (MemTrim) encodings
  localparam logic [1:0] TRIM_WORD = 2'b00;
  localparam logic [1:0] TRIM_HALF = 2'b01;
  localparam logic [1:0] TRIM_BYTE = 2'b10;

  // Unshifted store masks (MemWrite)
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WAIT_RSP = 2'd2
  } mem_state_e;

  // What the load extractor needs once the response comes back
  typedef struct packed {
    logic [1:0] offset;
    logic [1:0] trim;
    logic       sign;
  } load_ctx_t;

  // Access size of a store, derived from its unshifted mask
  function automatic logic [1:0] store_trim(input logic [3:0] mask);
    case (mask)
      MASK_WORD: return TRIM_WORD;
      MASK_HALF: return TRIM_HALF;
      default:   return TRIM_BYTE;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] trim, input logic [1:0] offset);
    case (trim)
      TRIM_WORD: return offset != 2'b00;
      TRIM_HALF: return offset[0];
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response bus.
//   master: req, we, addr, wdata out; gnt, rvalid, rdata in
//   slave : mirror image
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32
);
  logic              req;
  logic [3:0]        we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_align.sv
// Load extraction: selects the addressed byte/half lane of a read word and
// sign- or zero-extends it.
//   rdata  : raw bus word
//   offset : byte offset addr[1:0]
//   trim   : load size (TRIM_*)
//   sign   : 1 = sign-extend sub-word loads
//   data_c : aligned, extended load value (combinational)
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  trim,
  input  logic        sign,
  output logic [31:0] data_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    half_lane = rdata[15:0];
    data_c    = rdata;

    case (offset)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase

    // Aligned halves only; offset[0] is excluded by the misalignment check
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    case (trim)
      TRIM_HALF: data_c = {{16{sign & half_lane[15]}}, half_lane};
      TRIM_BYTE: data_c = {{24{sign & byte_lane[7]}}, byte_lane};
      default:   data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores from the EX/MEM set onto the data
// bus, stalls upstream while a transaction is outstanding, and registers the
// MEM/WB set.
//   clk, rst_n               : clock, async active-low reset
//   ex_mem_reg_*             : EX/MEM register inputs
//   dmem                     : data-memory bus (master side)
//   mem_wb_reg_*             : registered MEM/WB outputs
//   mem_stage_alu_result     : combinational forwarding copy of the ALU result
//   mem_stage_stall          : combinational upstream freeze
//   mem_stage_misaligned     : one-cycle pulse for a suppressed misaligned access
module mem_stage
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic [XLEN-1:0] ex_mem_reg_alu_result,
  input  logic [XLEN-1:0] ex_mem_reg_rs2_data,
  input  logic [4:0]      ex_mem_reg_rd_adr,
  input  logic            ex_mem_reg_wb_ctrl_RegWrite,
  input  logic            ex_mem_reg_wb_ctrl_MemtoReg,
  input  logic            ex_mem_reg_wb_ctrl_MemSign,
  input  logic [1:0]      ex_mem_reg_wb_ctrl_MemTrim,
  input  logic            ex_mem_reg_mem_ctrl_MemRead,
  input  logic [3:0]      ex_mem_reg_mem_ctrl_MemWrite,

  mem_stage_if.master     dmem,

  output logic [XLEN-1:0] mem_wb_reg_alu_result,
  output logic [XLEN-1:0] mem_wb_reg_mem_rdata,
  output logic [4:0]      mem_wb_reg_rd_adr,
  output logic            mem_wb_reg_wb_ctrl_RegWrite,
  output logic            mem_wb_reg_wb_ctrl_MemtoReg,

  output logic [XLEN-1:0] mem_stage_alu_result,
  output logic            mem_stage_stall,
  output logic            mem_stage_misaligned
);

  mem_state_e  state_q, state_d;
  load_ctx_t   ctx_q, ctx_d;
  logic [1:0]  offset;
  logic        is_store;
  logic        mem_op;
  logic [1:0]  access_trim;
  logic        misaligned_c;
  logic        valid_mem_c;
  logic        req_c;
  logic        rsp_done_c;
  logic [31:0] load_data_c;

  // Access decode; a store wins over a simultaneous MemRead
  always_comb begin
    offset       = ex_mem_reg_alu_result[1:0];
    is_store     = |ex_mem_reg_mem_ctrl_MemWrite;
    mem_op       = ex_mem_reg_mem_ctrl_MemRead | is_store;
    access_trim  = is_store ? store_trim(ex_mem_reg_mem_ctrl_MemWrite)
                            : ex_mem_reg_wb_ctrl_MemTrim;
    misaligned_c = mem_op & is_misaligned(access_trim, offset);
    valid_mem_c  = mem_op & ~misaligned_c;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state and request
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_mem_c) begin
          req_c   = 1'b1;
          state_d = dmem.gnt ? ST_WAIT_RSP : ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        req_c = 1'b1;
        if (dmem.gnt) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (dmem.rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_done_c      = (state_q == ST_WAIT_RSP) & dmem.rvalid;
  assign mem_stage_stall = valid_mem_c & ~rsp_done_c;
  assign mem_stage_alu_result = ex_mem_reg_alu_result;

  // Request fields come straight from EX/MEM, which the stall holds steady
  assign dmem.req   = req_c;
  assign dmem.addr  = req_c ? ADDR_W'({ex_mem_reg_alu_result[XLEN-1:2], 2'b00}) : '0;
  assign dmem.we    = (req_c && is_store) ? 4'(ex_mem_reg_mem_ctrl_MemWrite << offset) : 4'b0000;
  assign dmem.wdata = (req_c && is_store) ? XLEN'(ex_mem_reg_rs2_data << {offset, 3'b000}) : '0;

  // Load context captured when the request is accepted
  always_comb begin
    ctx_d = ctx_q;
    if (req_c && dmem.gnt) begin
      ctx_d.offset = offset;
      ctx_d.trim   = ex_mem_reg_wb_ctrl_MemTrim;
      ctx_d.sign   = ex_mem_reg_wb_ctrl_MemSign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctx_q <= '0;
    else        ctx_q <= ctx_d;
  end

  load_align u_load_align (
    .rdata  (dmem.rdata),
    .offset (ctx_q.offset),
    .trim   (ctx_q.trim),
    .sign   (ctx_q.sign),
    .data_c (load_data_c)
  );

  // MEM/WB register: bubbles while stalled, instruction otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_reg_alu_result       <= '0;
      mem_wb_reg_mem_rdata        <= '0;
      mem_wb_reg_rd_adr           <= '0;
      mem_wb_reg_wb_ctrl_RegWrite <= 1'b0;
      mem_wb_reg_wb_ctrl_MemtoReg <= 1'b0;
      mem_stage_misaligned        <= 1'b0;
    end else begin
      mem_wb_reg_alu_result <= ex_mem_reg_alu_result;
      mem_stage_misaligned  <= misaligned_c;
      if (mem_stage_stall) begin
        mem_wb_reg_rd_adr           <= '0;
        mem_wb_reg_wb_ctrl_RegWrite <= 1'b0;
        mem_wb_reg_wb_ctrl_MemtoReg <= 1'b0;
      end else begin
        mem_wb_reg_rd_adr           <= ex_mem_reg_rd_adr;
        mem_wb_reg_wb_ctrl_RegWrite <= ex_mem_reg_wb_ctrl_RegWrite & ~misaligned_c;
        mem_wb_reg_wb_ctrl_MemtoReg <= ex_mem_reg_wb_ctrl_MemtoReg;
        if (rsp_done_c) mem_wb_reg_mem_rdata <= XLEN'(load_data_c);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected MEM/WB results.
module tb_mem_stage;
  import core_pkg::*;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        chk_rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] ex_alu, ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_rw, ex_m2r, ex_sign, ex_read;
  logic [1:0]  ex_trim;
  logic [3:0]  ex_write;

  logic [31:0] wb_alu, wb_rdata, fwd_alu;
  logic [4:0]  wb_rd;
  logic        wb_rw, wb_m2r, stall, misaligned;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  mem_stage_if #(.ADDR_W(32), .XLEN(32)) dmem_bus ();

  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .ex_mem_reg_alu_result        (ex_alu),
    .ex_mem_reg_rs2_data          (ex_rs2),
    .ex_mem_reg_rd_adr            (ex_rd),
    .ex_mem_reg_wb_ctrl_RegWrite  (ex_rw),
    .ex_mem_reg_wb_ctrl_MemtoReg  (ex_m2r),
    .ex_mem_reg_wb_ctrl_MemSign   (ex_sign),
    .ex_mem_reg_wb_ctrl_MemTrim   (ex_trim),
    .ex_mem_reg_mem_ctrl_MemRead  (ex_read),
    .ex_mem_reg_mem_ctrl_MemWrite (ex_write),
    .dmem                         (dmem_bus),
    .mem_wb_reg_alu_result        (wb_alu),
    .mem_wb_reg_mem_rdata         (wb_rdata),
    .mem_wb_reg_rd_adr            (wb_rd),
    .mem_wb_reg_wb_ctrl_RegWrite  (wb_rw),
    .mem_wb_reg_wb_ctrl_MemtoReg  (wb_m2r),
    .mem_stage_alu_result         (fwd_alu),
    .mem_stage_stall              (stall),
    .mem_stage_misaligned         (misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_exp(input logic [31:0] alu, input logic [31:0] rdata,
                                  input logic [4:0] rd, input logic rw, input logic m2r,
                                  input logic chk_rdata);
    exp_t e;
    e.alu = alu; e.rdata = rdata; e.rd = rd;
    e.rw = rw; e.m2r = m2r; e.chk_rdata = chk_rdata;
    return e;
  endfunction

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic m2r, input logic sign,
                          input logic [1:0] trim, input logic rd_en, input logic [3:0] wr);
    ex_alu = alu; ex_rs2 = rs2; ex_rd = rd; ex_rw = rw; ex_m2r = m2r;
    ex_sign = sign; ex_trim = trim; ex_read = rd_en; ex_write = wr;
  endtask

  task automatic drive_nop();
    drive_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, TRIM_WORD, 1'b0, 4'b0000);
  endtask

  // Pop the oldest expectation and compare against the MEM/WB register
  task automatic check_wb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb_underflow: observed empty queue expected one entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_wb_alu"}, wb_alu, e.alu);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
    chk({tag, "_wb_regwrite"}, 32'(wb_rw), 32'(e.rw));
    chk({tag, "_wb_memtoreg"}, 32'(wb_m2r), 32'(e.m2r));
    if (e.chk_rdata) chk({tag, "_wb_rdata"}, wb_rdata, e.rdata);
  endtask

  // Run one bus transaction for the op currently driven on EX/MEM.
  // gnt arrives gnt_dly cycles after the first request cycle, rvalid
  // rsp_dly cycles after gnt.
  task automatic run_mem(input string tag, input int gnt_dly, input int rsp_dly,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_we, input logic [31:0] exp_wdata, input exp_t e);
    int  n_stall = 0;
    bit  done = 1'b0;
    sb.push_back(e);
    for (int c = 0; c < 40; c++) begin
      dmem_bus.gnt    = (c == gnt_dly);
      dmem_bus.rvalid = (c == gnt_dly + rsp_dly);
      dmem_bus.rdata  = dmem_bus.rvalid ? rdata : 32'h5A5A_5A5A;
      #1;
      if (c <= gnt_dly) begin
        chk({tag, "_req"}, 32'(dmem_bus.req), 32'd1);
        chk({tag, "_addr"}, dmem_bus.addr, exp_addr);
        chk({tag, "_we"}, 32'(dmem_bus.we), 32'(exp_we));
        if (exp_we != 4'b0000) chk({tag, "_wdata"}, dmem_bus.wdata, exp_wdata);
      end else begin
        chk({tag, "_req_low"}, 32'(dmem_bus.req), 32'd0);
      end
      if (stall) n_stall++;
      done = dmem_bus.rvalid;
      tick();
      if (done) break;
      chk({tag, "_bubble_rw"}, 32'(wb_rw), 32'd0);
      chk({tag, "_bubble_rd"}, 32'(wb_rd), 32'd0);
    end
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed no response expected rvalid within 40 cycles", tag);
    end
    chk({tag, "_stall_cycles"}, 32'(n_stall), 32'(gnt_dly + rsp_dly));
    check_wb(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_nop();
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = 32'h0;
    repeat (2) tick();

    // Reset state
    chk("rst_req", 32'(dmem_bus.req), 32'd0);
    chk("rst_we", 32'(dmem_bus.we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_wb_alu", wb_alu, 32'd0);
    chk("rst_wb_rdata", wb_rdata, 32'd0);
    chk("rst_wb_rw", 32'(wb_rw), 32'd0);
    rst_n = 1'b1;

    // Plain ALU op: one-cycle pass-through, no bus activity
    drive_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, TRIM_WORD, 1'b0, 4'b0000);
    #1;
    chk("alu_req", 32'(dmem_bus.req), 32'd0);
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_fwd", fwd_alu, 32'h1234);
    sb.push_back(mk_exp(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0));
    tick();
    check_wb("alu");

    // Zero-wait word load
    drive_op(32'h100, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, TRIM_WORD, 1'b1, 4'b0000);
    run_mem("ldw", 0, 1, 32'hDEAD_BEEF, 32'h100, 4'b0000, 32'h0,
            mk_exp(32'h100, 32'hDEAD_BEEF, 5'd6, 1'b1, 1'b1, 1'b1));

    // Signed and unsigned half loads from the upper lane
    drive_op(32'h102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, TRIM_HALF, 1'b1, 4'b0000);
    run_mem("ldh_s", 0, 1, 32'h8001_0000, 32'h100, 4'b0000, 32'h0,
            mk_exp(32'h102, 32'hFFFF_8001, 5'd7, 1'b1, 1'b1, 1'b1));
    drive_op(32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, TRIM_HALF, 1'b1, 4'b0000);
    run_mem("ldh_u", 0, 1, 32'h8001_0000, 32'h100, 4'b0000, 32'h0,
            mk_exp(32'h102, 32'h0000_8001, 5'd8, 1'b1, 1'b1, 1'b1));

    // Signed byte loads: positive lane 1, negative lane 3
    drive_op(32'h501, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, TRIM_BYTE, 1'b1, 4'b0000);
    run_mem("ldb_1", 0, 1, 32'h80FF_7F01, 32'h500, 4'b0000, 32'h0,
            mk_exp(32'h501, 32'h0000_007F, 5'd9, 1'b1, 1'b1, 1'b1));
    drive_op(32'h503, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, TRIM_BYTE, 1'b1, 4'b0000);
    run_mem("ldb_3", 0, 1, 32'h80FF_7F01, 32'h500, 4'b0000, 32'h0,
            mk_exp(32'h503, 32'hFFFF_FF80, 5'd10, 1'b1, 1'b1, 1'b1));

    // Byte store to the top lane
    drive_op(32'h203, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b0, TRIM_WORD, 1'b0, MASK_BYTE);
    run_mem("stb", 0, 1, 32'h0, 32'h200, 4'b1000, 32'hAB00_0000,
            mk_exp(32'h203, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));

    // Half store, upper half, one cycle of grant delay
    drive_op(32'h306, 32'h1234_CDEF, 5'd0, 1'b0, 1'b0, 1'b0, TRIM_WORD, 1'b0, MASK_HALF);
    run_mem("sth", 1, 1, 32'h0, 32'h304, 4'b1100, 32'hCDEF_0000,
            mk_exp(32'h306, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));

    // Slow memory: grant after 3 cycles, response 2 cycles later
    drive_op(32'h300, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, TRIM_WORD, 1'b1, 4'b0000);
    run_mem("ld_slow", 3, 2, 32'h1357_2468, 32'h300, 4'b0000, 32'h0,
            mk_exp(32'h300, 32'h1357_2468, 5'd11, 1'b1, 1'b1, 1'b1));

    // Misaligned word load: suppressed, no stall, RegWrite cleared
    drive_op(32'h101, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, TRIM_WORD, 1'b1, 4'b0000);
    #1;
    chk("mis_w_req", 32'(dmem_bus.req), 32'd0);
    chk("mis_w_stall", 32'(stall), 32'd0);
    sb.push_back(mk_exp(32'h101, 32'h0, 5'd12, 1'b0, 1'b1, 1'b0));
    tick();
    chk("mis_w_pulse", 32'(misaligned), 32'd1);
    check_wb("mis_w");

    // Misaligned half store at an odd address
    drive_op(32'h201, 32'hFFFF, 5'd0, 1'b0, 1'b0, 1'b0, TRIM_WORD, 1'b0, MASK_HALF);
    #1;
    chk("mis_h_req", 32'(dmem_bus.req), 32'd0);
    chk("mis_h_we", 32'(dmem_bus.we), 32'd0);
    tick();
    chk("mis_h_pulse", 32'(misaligned), 32'd1);
    drive_nop();
    tick();
    chk("mis_pulse_end", 32'(misaligned), 32'd0);

    // Reset while waiting for a response; the late response is ignored
    drive_op(32'h400, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, TRIM_WORD, 1'b1, 4'b0000);
    dmem_bus.gnt = 1'b1;
    #1;
    chk("rrsp_req", 32'(dmem_bus.req), 32'd1);
    tick();
    dmem_bus.gnt = 1'b0;
    #1;
    chk("rrsp_wait_req", 32'(dmem_bus.req), 32'd0);
    chk("rrsp_wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    drive_nop();
    #1;
    chk("rrsp_req_low", 32'(dmem_bus.req), 32'd0);
    chk("rrsp_we", 32'(dmem_bus.we), 32'd0);
    chk("rrsp_stall", 32'(stall), 32'd0);
    chk("rrsp_wb_alu", wb_alu, 32'd0);
    chk("rrsp_wb_rdata", wb_rdata, 32'd0);
    chk("rrsp_wb_rd", 32'(wb_rd), 32'd0);
    chk("rrsp_wb_rw", 32'(wb_rw), 32'd0);
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'hBAD0_BAD0;
    tick();
    rst_n = 1'b1;
    tick();
    dmem_bus.rvalid = 1'b0;
    chk("late_rsp_rdata", wb_rdata, 32'd0);
    chk("late_rsp_rw", 32'(wb_rw), 32'd0);

    // Pipeline recovers after reset
    drive_op(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, TRIM_WORD, 1'b0, 4'b0000);
    sb.push_back(mk_exp(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0));
    tick();
    check_wb("recover");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
